// File: rtl/qbuff_gen.sv
// ---------------------------------------------------------------------------
// qbuff_gen -- triggered capture buffer for L-lane sample streams
//
// Samples are delayed by a runtime pre-trigger depth and qualified per word by
// a 4-mode threshold comparator. During trigger windows they are written into
// an external dual-port memory. Supports multi-window accumulation, circular
// (wrap) capture and status readback.
//
// Pipeline:
//   stage 0 : din / trigger registered
//   tap     : stage-0 word delayed PRE_DLY cycles (0 = stage-0 word itself)
//   stage 1 : qualifier and tap data registered
//   stage 2 : memory write port registered
//   Trigger high at edge t -> mem_we at edge t+2 with din sampled at t-PRE_DLY.
//
// Ports:
//   aclk, aresetn    clock, asynchronous active-low reset
//   din, trigger     lane stream (lane i at din[i*B +: B]) and capture window
//   mem_we/addr/di   memory write port
//   COMP_MODE_REG    0=all, 1=above, 2=below, 3=rising crossing
//   COMP_THR_REG     signed threshold
//   PRE_DLY_REG      pre-trigger delay in cycles (0..DLY-1)
//   WRAP_REG         0=stop when full, 1=circular
//   WMEM_START_REG   level; rising edge arms, low aborts / returns to idle
//   WMEM_ADDR_REG    region base address
//   WMEM_NSAMP_REG   region size in words (0 = no capture)
//   BUSY_REG         armed or capturing
//   DONE_REG         capture complete
//   OVF_REG          circular region wrapped at least once
//   NCAP_REG         words written since arm (mod region size in wrap mode)
// ---------------------------------------------------------------------------
module qbuff_gen #(
    parameter  int DLY = 32,
    parameter  int B   = 16,
    parameter  int L   = 4,
    parameter  int N   = 10,
    localparam int DW  = $clog2(DLY)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [L*B-1:0]   din,
    input  logic             trigger,
    output logic             mem_we,
    output logic [N-1:0]     mem_addr,
    output logic [L*B-1:0]   mem_di,
    input  logic [1:0]       COMP_MODE_REG,
    input  logic [B-1:0]     COMP_THR_REG,
    input  logic [DW-1:0]    PRE_DLY_REG,
    input  logic             WRAP_REG,
    input  logic             WMEM_START_REG,
    input  logic [N-1:0]     WMEM_ADDR_REG,
    input  logic [N-1:0]     WMEM_NSAMP_REG,
    output logic             BUSY_REG,
    output logic             DONE_REG,
    output logic             OVF_REG,
    output logic [N-1:0]     NCAP_REG
);

    localparam int W = L * B;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // ---------------------------------------------------------------
    // Configuration latched on START rising edge
    // ---------------------------------------------------------------
    logic [1:0]          r_mode;
    logic signed [B-1:0] r_thr;
    logic [DW-1:0]       r_pre;
    logic                r_wrap;
    logic [N-1:0]        r_addr;
    logic [N-1:0]        r_nsamp;

    // ---------------------------------------------------------------
    // Stage 0 and delay line
    // ---------------------------------------------------------------
    logic [W-1:0] r_din0;
    logic         r_trig0;
    logic [W-1:0] r_dly [1:DLY-1];   // r_dly[k] = r_din0 delayed k cycles
    logic [W-1:0] w_tap;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_din0  <= '0;
            r_trig0 <= 1'b0;
        end else begin
            r_din0  <= din;
            r_trig0 <= trigger;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DLY; gi++) begin : g_dly
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_dly[gi] <= '0;
                end else if (gi == 1) begin
                    r_dly[gi] <= r_din0;
                end else begin
                    r_dly[gi] <= r_dly[gi-1];
                end
            end
        end
    endgenerate

    // Explicit compare-select so an out-of-range delay yields the undelayed
    // word instead of an undefined array read.
    always_comb begin
        w_tap = r_din0;
        for (int k = 1; k < DLY; k++) begin
            if (r_pre == DW'(k)) begin
                w_tap = r_dly[k];
            end
        end
    end

    // ---------------------------------------------------------------
    // Comparator
    // ---------------------------------------------------------------
    logic signed [B-1:0] r_prev_last;   // lane L-1 of the previous tap word
    logic [L-1:0]        w_above;
    logic [L-1:0]        w_below;
    logic [L-1:0]        w_rise;
    logic                w_qual;

    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            logic signed [B-1:0] w_x;
            logic signed [B-1:0] w_p;
            assign w_x = w_tap[gi*B +: B];
            if (gi == 0) begin : g_first
                assign w_p = r_prev_last;
            end else begin : g_rest
                assign w_p = w_tap[(gi-1)*B +: B];
            end
            assign w_above[gi] = (w_x > r_thr);
            assign w_below[gi] = (w_x < r_thr);
            assign w_rise[gi]  = (w_x > r_thr) && !(w_p > r_thr);
        end
    endgenerate

    always_comb begin
        w_qual = 1'b0;
        case (r_mode)
            2'd0:    w_qual = 1'b1;
            2'd1:    w_qual = |w_above;
            2'd2:    w_qual = |w_below;
            default: w_qual = |w_rise;
        endcase
    end

    // ---------------------------------------------------------------
    // Stage 1: qualifier + data; crossing history runs every cycle
    // ---------------------------------------------------------------
    logic         r_qual1;
    logic [W-1:0] r_data1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_qual1     <= 1'b0;
            r_data1     <= '0;
            r_prev_last <= '0;
        end else begin
            r_qual1     <= w_qual;
            r_data1     <= w_tap;
            r_prev_last <= w_tap[(L-1)*B +: B];
        end
    end

    // ---------------------------------------------------------------
    // Control FSM, capture counter and memory write port (stage 2)
    // ---------------------------------------------------------------
    logic [1:0]   r_state;
    logic         r_start_d;
    logic [N-1:0] r_ncap;
    logic         r_ovf;
    logic         r_mem_we;
    logic [N-1:0] r_mem_addr;
    logic [W-1:0] r_mem_di;

    logic         w_write;
    logic [N:0]   w_ncap_inc;
    logic         w_last;

    // START low suppresses the write at the same edge it returns to idle.
    assign w_write    = (r_state == S_CAPT) && r_qual1 && WMEM_START_REG;
    assign w_ncap_inc = {1'b0, r_ncap} + {{N{1'b0}}, 1'b1};
    assign w_last     = (w_ncap_inc == {1'b0, r_nsamp});

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_start_d  <= 1'b0;
            r_ncap     <= '0;
            r_ovf      <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_di   <= '0;
            r_mode     <= '0;
            r_thr      <= '0;
            r_pre      <= '0;
            r_wrap     <= 1'b0;
            r_addr     <= '0;
            r_nsamp    <= '0;
        end else begin
            r_start_d <= WMEM_START_REG;
            r_mem_we  <= w_write;
            if (w_write) begin
                r_mem_addr <= r_addr + r_ncap;
                r_mem_di   <= r_data1;
            end

            if (!WMEM_START_REG) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_start_d) begin
                            r_mode  <= COMP_MODE_REG;
                            r_thr   <= COMP_THR_REG;
                            r_pre   <= PRE_DLY_REG;
                            r_wrap  <= WRAP_REG;
                            r_addr  <= WMEM_ADDR_REG;
                            r_nsamp <= WMEM_NSAMP_REG;
                            r_ncap  <= '0;
                            r_ovf   <= 1'b0;
                            r_state <= (WMEM_NSAMP_REG == '0) ? S_DONE : S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (r_trig0) begin
                            r_state <= S_CAPT;
                        end
                    end
                    S_CAPT: begin
                        if (w_write && w_last && !r_wrap) begin
                            // Final word of a one-shot region: DONE wins over
                            // a simultaneous trigger fall.
                            r_ncap  <= w_ncap_inc[N-1:0];
                            r_state <= S_DONE;
                        end else begin
                            if (w_write) begin
                                if (w_last) begin
                                    r_ncap <= '0;
                                    r_ovf  <= 1'b1;
                                end else begin
                                    r_ncap <= w_ncap_inc[N-1:0];
                                end
                            end
                            if (!r_trig0) begin
                                r_state <= S_ARMED;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_DONE;
                    end
                endcase
            end
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_di   = r_mem_di;
    assign BUSY_REG = (r_state == S_ARMED) || (r_state == S_CAPT);
    assign DONE_REG = (r_state == S_DONE);
    assign OVF_REG  = r_ovf;
    assign NCAP_REG = r_ncap;

endmodule

// File: tb/tb_qbuff_gen.sv
// ---------------------------------------------------------------------------
// tb_qbuff_gen -- randomized scoreboard bench for qbuff_gen
//
// The stimulus process drives one word per cycle and, after every clock edge,
// advances a sample-level reference model: a sample whose trigger was seen at
// edge c in an active session produces an expected write (addr, data) two
// edges later if any lane qualifies. The monitor process, on each falling
// edge, matches observed writes against the expectation queue and compares
// the status outputs with the model.
// ---------------------------------------------------------------------------
module tb_qbuff_gen;

    localparam int DLY  = 32;
    localparam int B    = 16;
    localparam int L    = 4;
    localparam int N    = 10;
    localparam int W    = L * B;
    localparam int DW   = $clog2(DLY);
    localparam int HMAX = 16384;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  din = '0;
    logic          trigger = 1'b0;
    logic          mem_we;
    logic [N-1:0]  mem_addr;
    logic [W-1:0]  mem_di;
    logic [1:0]    COMP_MODE_REG = '0;
    logic [B-1:0]  COMP_THR_REG = '0;
    logic [DW-1:0] PRE_DLY_REG = '0;
    logic          WRAP_REG = 1'b0;
    logic          WMEM_START_REG = 1'b0;
    logic [N-1:0]  WMEM_ADDR_REG = '0;
    logic [N-1:0]  WMEM_NSAMP_REG = '0;
    logic          BUSY_REG;
    logic          DONE_REG;
    logic          OVF_REG;
    logic [N-1:0]  NCAP_REG;

    qbuff_gen #(.DLY(DLY), .B(B), .L(L), .N(N)) dut (
        .aclk(aclk), .aresetn(aresetn), .din(din), .trigger(trigger),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .COMP_MODE_REG(COMP_MODE_REG), .COMP_THR_REG(COMP_THR_REG),
        .PRE_DLY_REG(PRE_DLY_REG), .WRAP_REG(WRAP_REG),
        .WMEM_START_REG(WMEM_START_REG), .WMEM_ADDR_REG(WMEM_ADDR_REG),
        .WMEM_NSAMP_REG(WMEM_NSAMP_REG), .BUSY_REG(BUSY_REG),
        .DONE_REG(DONE_REG), .OVF_REG(OVF_REG), .NCAP_REG(NCAP_REG)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [N-1:0] addr;
        logic [W-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- reference model ----------------
    logic [W-1:0] hist   [0:HMAX-1];
    bit           trig_h [0:HMAX-1];
    int edge_n     = 0;
    int valid_from = 0;
    bit m_prev_start = 0, m_active = 0, m_done = 0, m_ovf = 0;
    int m_ncap = 0, m_mode = 0, m_thr = 0, m_pre = 0, m_addr = 0, m_nsamp = 0;
    bit m_wrap = 0;
    int m_arm_edge = 0;

    function automatic logic [W-1:0] word_at(input int e);
        if (e < valid_from || e < 0) return '0;
        return hist[e];
    endfunction

    function automatic int lane(input logic [W-1:0] w, input int i);
        logic signed [B-1:0] v;
        v = w[i*B +: B];
        return int'(v);
    endfunction

    function automatic bit qualifies(input logic [W-1:0] w, input logic [W-1:0] pw);
        bit any = 0;
        for (int i = 0; i < L; i++) begin
            int x = lane(w, i);
            int p = (i == 0) ? lane(pw, L-1) : lane(w, i-1);
            case (m_mode)
                0: any = 1;
                1: if (x > m_thr) any = 1;
                2: if (x < m_thr) any = 1;
                default: if (x > m_thr && p <= m_thr) any = 1;
            endcase
        end
        return any;
    endfunction

    task automatic model_edge(input logic [W-1:0] d, input bit t, input bit s);
        int c;
        exp_t e;
        hist[edge_n]   = d;
        trig_h[edge_n] = t;
        if (!s) begin
            m_active = 0;
        end else if (!m_prev_start) begin
            m_mode     = int'(COMP_MODE_REG);
            m_thr      = lane({{(W-B){1'b0}}, COMP_THR_REG}, 0);
            m_pre      = int'(PRE_DLY_REG);
            m_wrap     = WRAP_REG;
            m_addr     = int'(WMEM_ADDR_REG);
            m_nsamp    = int'(WMEM_NSAMP_REG);
            m_ncap     = 0;
            m_ovf      = 0;
            m_done     = (m_nsamp == 0);
            m_active   = 1;
            m_arm_edge = edge_n;
        end else if (m_active && !m_done) begin
            c = edge_n - 2;
            if (c >= m_arm_edge && trig_h[c]) begin
                if (qualifies(word_at(c - m_pre), word_at(c - m_pre - 1))) begin
                    e.addr = N'((m_addr + m_ncap) % (1 << N));
                    e.data = word_at(c - m_pre);
                    exp_q.push_back(e);
                    m_ncap++;
                    if (m_ncap == m_nsamp) begin
                        if (m_wrap) begin
                            m_ncap = 0;
                            m_ovf  = 1;
                        end else begin
                            m_done = 1;
                        end
                    end
                end
            end
        end
        m_prev_start = s;
        if (edge_n < HMAX-1) edge_n++;
    endtask

    // ---------------- monitor ----------------
    always @(negedge aclk) begin
        if (mon_en && aresetn) begin
            if (mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_di);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_di !== e.data) begin
                        errors++;
                        $display("FAIL write_payload: got addr=%0d data=%h, required addr=%0d data=%h",
                                 mem_addr, mem_di, e.addr, e.data);
                    end else begin
                        $display("write addr=%0d data=%h ok", mem_addr, mem_di);
                    end
                end
            end else if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: got mem_we=0, required write addr=%0d data=%h", e.addr, e.data);
            end
            checks++;
            if (BUSY_REG !== (m_active && !m_done) || DONE_REG !== (m_active && m_done) ||
                OVF_REG !== m_ovf || NCAP_REG !== N'(m_ncap)) begin
                errors++;
                $display("FAIL status: got busy=%0b done=%0b ovf=%0b ncap=%0d, required busy=%0b done=%0b ovf=%0b ncap=%0d",
                         BUSY_REG, DONE_REG, OVF_REG, NCAP_REG,
                         m_active && !m_done, m_active && m_done, m_ovf, m_ncap);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] rand_word(input int style);
        logic [W-1:0] w;
        for (int i = 0; i < L; i++) begin
            int v;
            if (style == 0) v = int'($urandom);
            else v = int'($urandom_range(0, 12)) - 6;
            w[i*B +: B] = B'(v);
        end
        return w;
    endfunction

    // Called at posedge+1: drive, wait for the edge, advance the model.
    task automatic step(input logic [W-1:0] d, input bit t, input bit s);
        din = d;
        trigger = t;
        WMEM_START_REG = s;
        @(posedge aclk);
        #1;
        model_edge(d, t, s);
    endtask

    // tmode 0: trigger held high; 1: random windows. abort_at < 0: no abort.
    task automatic run_session(input int mode, input int thr, input int pre, input bit wrap,
                               input int addr, input int nsamp, input int len,
                               input int abort_at, input int style, input int tmode);
        bit t, s;
        repeat (2) step(rand_word(style), 1'b0, 1'b0);
        COMP_MODE_REG  = 2'(mode);
        COMP_THR_REG   = B'(thr);
        PRE_DLY_REG    = DW'(pre);
        WRAP_REG       = wrap;
        WMEM_ADDR_REG  = N'(addr);
        WMEM_NSAMP_REG = N'(nsamp);
        step(rand_word(style), 1'b0, 1'b1);
        // Later register changes must be ignored until the next arm.
        COMP_MODE_REG  = 2'($urandom);
        COMP_THR_REG   = B'($urandom);
        PRE_DLY_REG    = DW'($urandom);
        WRAP_REG       = 1'($urandom);
        WMEM_ADDR_REG  = N'($urandom);
        WMEM_NSAMP_REG = N'($urandom);
        step(rand_word(style), 1'b0, 1'b1);
        for (int i = 0; i < len; i++) begin
            t = (tmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s = !(abort_at >= 0 && i >= abort_at);
            step(rand_word(style), t, s);
        end
        repeat (3) step(rand_word(style), 1'($urandom), 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_di !== '0 || BUSY_REG !== 1'b0 ||
            DONE_REG !== 1'b0 || OVF_REG !== 1'b0 || NCAP_REG !== '0) begin
            errors++;
            $display("FAIL reset_state: got we=%0b addr=%0d busy=%0b done=%0b ovf=%0b ncap=%0d, required all 0",
                     mem_we, mem_addr, BUSY_REG, DONE_REG, OVF_REG, NCAP_REG);
        end
        aresetn = 1'b1;
        valid_from = edge_n;
        mon_en = 1'b1;

        // one-shot, 8 words, trigger held high
        run_session(0, 0, 0, 0, 0, 8, 20, -1, 0, 0);
        // circular region at base 5 of size 4
        run_session(0, 0, 0, 1, 5, 4, 12, -1, 0, 0);
        // pre-trigger delay of 10
        run_session(0, 0, 10, 0, 100, 6, 12, -1, 0, 0);
        // maximum pre-trigger delay
        run_session(0, 0, DLY-1, 0, 200, 5, 10, -1, 0, 0);
        // empty region goes straight to DONE
        run_session(0, 0, 0, 0, 0, 0, 8, -1, 0, 0);
        // abort mid-window
        run_session(0, 0, 0, 0, 300, 50, 12, 5, 0, 0);
        // address wrap modulo memory size
        run_session(0, 0, 3, 0, 1020, 9, 14, -1, 0, 1);
        // rising-crossing with small values around zero
        run_session(3, 0, 2, 0, 40, 30, 40, -1, 1, 1);
        // above / below thresholds
        run_session(1, 3, 0, 0, 60, 20, 30, -1, 1, 1);
        run_session(2, -4, 5, 1, 70, 6, 30, -1, 1, 1);

        for (int n = 0; n < 30; n++) begin
            int style = int'($urandom_range(0, 1));
            int thr   = (style == 1) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 65535)) - 32768;
            int ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_session(int'($urandom_range(0, 3)), thr, int'($urandom_range(0, DLY-1)),
                        1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 20)),
                        int'($urandom_range(20, 60)), ab, style, int'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a capture
        repeat (2) step(rand_word(0), 1'b0, 1'b0);
        COMP_MODE_REG = 2'd0; WRAP_REG = 1'b0; PRE_DLY_REG = '0;
        WMEM_ADDR_REG = N'(10); WMEM_NSAMP_REG = N'(100);
        step(rand_word(0), 1'b0, 1'b1);
        repeat (6) step(rand_word(0), 1'b1, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || BUSY_REG !== 1'b0 || DONE_REG !== 1'b0 || NCAP_REG !== '0 || OVF_REG !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got we=%0b busy=%0b done=%0b ncap=%0d ovf=%0b, required all 0",
                     mem_we, BUSY_REG, DONE_REG, NCAP_REG, OVF_REG);
        end
        exp_q.delete();
        m_active = 0; m_done = 0; m_ovf = 0; m_ncap = 0; m_prev_start = 0;
        WMEM_START_REG = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        valid_from = edge_n;
        run_session(3, 0, 4, 0, 500, 15, 40, -1, 1, 1);

        repeat (3) step(rand_word(0), 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect: got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
